unified_mem_arbiter: RTL and testbench
======================================

# unified_mem_arbiter

Shares one single-port unified instruction/data memory between the fetch stage and the memory stage of the 5-stage RISC-V pipeline. Each side gets a request/done handshake. The block arbitrates with data-side priority and an anti-starvation limit, sequences one outstanding memory transaction at a time, and drives per-side stall signals into the hazard unit.

## Interface
- `ADDR_W`, 32, address width (byte address)
- `DATA_W`, 32, data width
- `MAX_DM_STREAK`, 4, consecutive data grants allowed while fetch waits (range 1..15)
- `clk`  in  1  clock, rising edge
- `arst_n`  in  1  reset, asynchronous, active-low
- `if_req`  in  1  fetch read request; held until `if_done`
- `if_addr`  in  ADDR_W  fetch address; stable while `if_req`
- `if_done`  out  1  one-cycle pulse: fetch transaction complete
- `if_rdata`  out  DATA_W  fetched instruction, valid with `if_done`
- `dm_req`  in  1  data request; held until `dm_done`
- `dm_we`  in  1  1 = store, 0 = load
- `dm_addr`  in  ADDR_W  data address
- `dm_wdata`  in  DATA_W  store data
- `dm_done`  out  1  one-cycle pulse: data transaction complete
- `dm_rdata`  out  DATA_W  load data, valid with `dm_done` when `dm_we`=0
- `mem_req`  out  1  memory request
- `mem_we`  out  1  memory write enable
- `mem_addr`  out  ADDR_W  memory address
- `mem_wdata`  out  DATA_W  memory write data
- `mem_ready`  in  1  memory accepts request this cycle
- `mem_rvalid`  in  1  read data valid
- `mem_rdata`  in  DATA_W  read data
- `stall_if`  out  1  `if_req & ~if_done` (combinational)
- `stall_dm`  out  1  `dm_req & ~dm_done` (combinational)

## Operation
- FSM states: IDLE, ISSUE, WAIT_RD, RESP.
- IDLE: arbitrate when any request is present; latch winner (`owner`), `we`, addr, and wdata into registers; go to ISSUE. No request: stay.
- Arbitration: only dm requests → DM. Only if requests → IF. Both requests → DM, unless `dm_streak == MAX_DM_STREAK`, in which case IF wins.
- `dm_streak` (4-bit): on a DM grant while `if_req`=1, increment (saturating at MAX_DM_STREAK). Clear on any IF grant. Clear on a DM grant with `if_req`=0.
- ISSUE: `mem_req`=1, driven from the latched registers. IF transactions always have `mem_we`=0. Hold until `mem_ready`=1.
  - On `mem_ready` with a write: go to RESP.
  - On `mem_ready` with a read: go to WAIT_RD.
- WAIT_RD: `mem_req`=0. On `mem_rvalid`, capture `mem_rdata` into the owner's rdata register and go to RESP. `mem_rvalid` outside WAIT_RD is ignored.
- RESP: pulse the owner's done signal for one cycle; go to IDLE. The requester deasserts or changes its request in the following cycle. IDLE re-samples only after RESP, so a held request is never double-granted.
- `if_rdata`/`dm_rdata` hold their last captured value until the next capture for that side.
- Only one transaction is outstanding at a time. A request arriving during ISSUE/WAIT_RD/RESP waits for IDLE.
- `stall_*` is high from request assertion through the cycle before its done pulse.

## Timing
- Reset (async assert, sync release): state=IDLE, `dm_streak`=0, and all outputs 0 (`mem_req`, `mem_we`, `mem_addr`, `mem_wdata`, `if_done`, `dm_done`, `if_rdata`, `dm_rdata`). `stall_*` follows its inputs. An in-flight transaction is dropped; a late `mem_rvalid` is ignored.
- Minimum store latency: request at cycle 0, `mem_req` at 1 (ready at 1), done at 2.
- Minimum load latency: request at 0, `mem_req` at 1 (ready), rvalid at 2, done at 3.
- Back-to-back throughput: one transaction per 3 cycles (store) or 4 cycles (load) at best.
- `mem_req` plus its address/data/we stay constant from ISSUE entry until `mem_ready`.
- A done pulse is never asserted for both sides in the same cycle.

## Test plan
- Single load: `dm_req`=1, `dm_we`=0, addr 0x100, `mem_ready` immediate, rvalid at next cycle with 0xDEADBEEF → `dm_done` at cycle 3 with `dm_rdata`=0xDEADBEEF; `if_done` stays 0.
- Store with backpressure: `dm_we`=1, addr 0x40, data 0x12345678, `mem_ready` low for 3 cycles → `mem_req`/addr/data held for 4 cycles; `dm_done` 1 cycle after ready; `stall_dm`=1 until then.
- Simultaneous requests: `if_req` and `dm_req` both set at cycle 0 → DM is served first and its done precedes `if_done`; `if_rdata` is correct for `if_addr` 0x0.
- Starvation guard, MAX_DM_STREAK=4: `if_req` held, `dm_req` re-asserted continuously → exactly 4 DM transactions, then 1 IF transaction, then DM resumes.
- Reset mid-read: `arst_n` low during WAIT_RD → outputs 0 immediately. After release, a stale `mem_rvalid` produces no done pulse, and a new fetch completes normally.
- Stray `mem_rvalid` while in IDLE or ISSUE → no capture and no done pulse.

Source files
------------

// File: rtl/unified_mem_arbiter.sv
// Arbitrates one single-port unified memory between the fetch and data sides,
// one transaction at a time, with data priority bounded by a streak limit.
module unified_mem_arbiter #(
    parameter int unsigned ADDR_W        = 32,
    parameter int unsigned DATA_W        = 32,
    parameter int unsigned MAX_DM_STREAK = 4
) (
    input  logic              clk,
    input  logic              arst_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_done,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic              dm_done,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ready,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              stall_if,
    output logic              stall_dm
);
    localparam int unsigned STREAK_W = 4;
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_DM_STREAK);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        WAIT_RD = 2'd2,
        RESP    = 2'd3
    } state_t;

    state_t              state, state_nx;
    logic                owner_dm, owner_dm_nx;
    logic [STREAK_W-1:0] dm_streak, dm_streak_nx;
    logic                mem_req_nx, mem_we_nx;
    logic [ADDR_W-1:0]   mem_addr_nx;
    logic [DATA_W-1:0]   mem_wdata_nx;
    logic                if_done_nx, dm_done_nx;
    logic [DATA_W-1:0]   if_rdata_nx, dm_rdata_nx;
    logic                grant_dm;

    // Stall each requester from request until its done pulse
    assign stall_if = if_req & ~if_done;
    assign stall_dm = dm_req & ~dm_done;

    // Data side wins unless fetch has already waited out the streak limit
    assign grant_dm = dm_req & (~if_req | (dm_streak != STREAK_MAX));

    // State register
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (if_req | dm_req) state_nx = ISSUE;
            ISSUE:   if (mem_ready)       state_nx = mem_we ? RESP : WAIT_RD;
            WAIT_RD: if (mem_rvalid)      state_nx = RESP;
            RESP:                         state_nx = IDLE;
            default:                      state_nx = IDLE;
        endcase
    end

    // Next values of the registered outputs and latched transaction fields
    always_comb begin
        mem_req_nx   = mem_req;
        mem_we_nx    = mem_we;
        mem_addr_nx  = mem_addr;
        mem_wdata_nx = mem_wdata;
        owner_dm_nx  = owner_dm;
        dm_streak_nx = dm_streak;
        if_rdata_nx  = if_rdata;
        dm_rdata_nx  = dm_rdata;
        if_done_nx   = 1'b0;
        dm_done_nx   = 1'b0;
        unique case (state)
            IDLE: begin
                if (if_req | dm_req) begin
                    owner_dm_nx  = grant_dm;
                    mem_req_nx   = 1'b1;
                    mem_we_nx    = grant_dm & dm_we;
                    mem_addr_nx  = grant_dm ? dm_addr : if_addr;
                    mem_wdata_nx = grant_dm ? dm_wdata : '0;
                    if (!grant_dm || !if_req) begin
                        dm_streak_nx = '0;
                    end else if (dm_streak != STREAK_MAX) begin
                        dm_streak_nx = dm_streak + STREAK_W'(1);
                    end
                end
            end
            ISSUE: begin
                if (mem_ready) begin
                    mem_req_nx = 1'b0;
                    mem_we_nx  = 1'b0;
                    if (mem_we) begin
                        if_done_nx = ~owner_dm;
                        dm_done_nx = owner_dm;
                    end
                end
            end
            WAIT_RD: begin
                if (mem_rvalid) begin
                    if (owner_dm) begin
                        dm_rdata_nx = mem_rdata;
                    end else begin
                        if_rdata_nx = mem_rdata;
                    end
                    if_done_nx = ~owner_dm;
                    dm_done_nx = owner_dm;
                end
            end
            default: ;
        endcase
    end

    // Output and transaction registers
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            owner_dm  <= 1'b0;
            dm_streak <= '0;
            if_rdata  <= '0;
            dm_rdata  <= '0;
            if_done   <= 1'b0;
            dm_done   <= 1'b0;
        end else begin
            mem_req   <= mem_req_nx;
            mem_we    <= mem_we_nx;
            mem_addr  <= mem_addr_nx;
            mem_wdata <= mem_wdata_nx;
            owner_dm  <= owner_dm_nx;
            dm_streak <= dm_streak_nx;
            if_rdata  <= if_rdata_nx;
            dm_rdata  <= dm_rdata_nx;
            if_done   <= if_done_nx;
            dm_done   <= dm_done_nx;
        end
    end

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Bench for unified_mem_arbiter: transaction-timing model plus directed scenarios.
`timescale 1ns/1ps
module tb_unified_mem_arbiter;
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int          MAXS   = 4;

    logic              clk = 1'b0;
    logic              arst_n;
    logic              if_req, dm_req, dm_we;
    logic [ADDR_W-1:0] if_addr, dm_addr;
    logic [DATA_W-1:0] dm_wdata;
    logic              if_done, dm_done;
    logic [DATA_W-1:0] if_rdata, dm_rdata;
    logic              mem_req, mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ready, mem_rvalid;
    logic [DATA_W-1:0] mem_rdata;
    logic              stall_if, stall_dm;

    always #5 clk = ~clk;

    unified_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_DM_STREAK(MAXS)) dut (
        .clk(clk), .arst_n(arst_n),
        .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_rdata(if_rdata),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_done(dm_done), .dm_rdata(dm_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ready(mem_ready), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .stall_if(stall_if), .stall_dm(stall_dm)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, exp, cyc);
        end
    endfunction

    // ---------------- memory environment ----------------
    logic [31:0] mem_img [bit [31:0]];
    int          ready_delay = 0;
    int          rv_delay = 1;
    int          req_age = 0;
    int          rv_cycle = -1;
    logic [31:0] rv_data = '0;
    int          acc_cnt = 0;
    int          mreq_hi_cnt = 0;
    int          stray_idle_cycle = -1;
    bit          stray_in_issue = 0;

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        return mem_img.exists(a) ? mem_img[a] : 32'h0;
    endfunction

    // Observe memory handshakes: apply stores, schedule read returns
    always @(negedge clk) begin
        if (mem_req) mreq_hi_cnt++;
        if (mem_req && mem_ready) begin
            req_age = 0;
            if (mem_we) begin
                mem_img[mem_addr] = mem_wdata;
            end else begin
                rv_cycle = cyc + rv_delay;
                rv_data  = mem_rd(mem_addr);
                acc_cnt++;
            end
        end else if (mem_req) begin
            req_age++;
        end else begin
            req_age = 0;
        end
    end

    // ---------------- requesters ----------------
    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } rq_t;

    rq_t         dm_q[$];
    rq_t         if_q[$];
    rq_t         drv_rq;
    bit          dm_busy = 0, if_busy = 0;
    int          dm_start = 0, if_start = 0, dm_lat = 0, if_lat = 0;
    logic [31:0] dm_rd_last = '0, if_rd_last = '0;
    int          dm_done_seen = 0, if_done_seen = 0;
    byte         order_q[$];

    // Drive memory responses and requester handshakes just after each edge
    always @(posedge clk) begin
        #1;
        mem_ready = mem_req && (req_age >= ready_delay);
        if (cyc == rv_cycle) begin
            mem_rvalid = 1'b1;
            mem_rdata  = rv_data;
        end else if ((cyc == stray_idle_cycle) || (stray_in_issue && mem_req && !mem_ready)) begin
            mem_rvalid = 1'b1;
            mem_rdata  = 32'hBADBAD00;
        end else begin
            mem_rvalid = 1'b0;
            mem_rdata  = 32'h5A5A0000 | 32'(cyc);
        end
        if (dm_done) dm_done_seen++;
        if (if_done) if_done_seen++;
        if (!arst_n) begin
            dm_busy = 0;
            if_busy = 0;
            dm_req  = 1'b0;
            if_req  = 1'b0;
        end else begin
            if (dm_busy && dm_done) begin
                dm_busy    = 0;
                dm_lat     = cyc - dm_start;
                dm_rd_last = dm_rdata;
                order_q.push_back(8'h44);
            end
            if (if_busy && if_done) begin
                if_busy    = 0;
                if_lat     = cyc - if_start;
                if_rd_last = if_rdata;
                order_q.push_back(8'h49);
            end
            if (!dm_busy && dm_q.size() != 0) begin
                drv_rq   = dm_q.pop_front();
                dm_req   = 1'b1;
                dm_we    = drv_rq.we;
                dm_addr  = drv_rq.addr;
                dm_wdata = drv_rq.wdata;
                dm_busy  = 1;
                dm_start = cyc;
            end
            if (!dm_busy) dm_req = 1'b0;
            if (!if_busy && if_q.size() != 0) begin
                drv_rq   = if_q.pop_front();
                if_req   = 1'b1;
                if_addr  = drv_rq.addr;
                if_busy  = 1;
                if_start = cyc;
            end
            if (!if_busy) if_req = 1'b0;
        end
    end

    // ---------------- behavioural model + per-cycle compare ----------------
    // One transaction at a time: granted at cycle g, mem_req from g+1 until
    // the ready cycle, done one cycle after ready (store) or after rvalid (load).
    bit          m_act = 0, m_dm = 0, m_we = 0, m_rdy = 0;
    int          m_g = 0, m_done = -1, m_run = 0;
    logic [31:0] m_addr = '0, m_wdata = '0, m_if_rd = '0, m_dm_rd = '0;
    bit          e_req, e_ifd, e_dmd, m_idle;

    always @(negedge clk) begin
        if (!arst_n) begin
            m_act   = 0;
            m_run   = 0;
            m_if_rd = '0;
            m_dm_rd = '0;
        end else begin
            e_req = m_act && (cyc > m_g) && !m_rdy;
            e_ifd = m_act && (cyc == m_done) && !m_dm;
            e_dmd = m_act && (cyc == m_done) && m_dm;
            chk("mem_req", 64'(mem_req), 64'(e_req));
            if (e_req) begin
                chk("mem_we", 64'(mem_we), 64'(m_we));
                chk("mem_addr", 64'(mem_addr), 64'(m_addr));
                if (m_we) chk("mem_wdata", 64'(mem_wdata), 64'(m_wdata));
            end
            chk("if_done", 64'(if_done), 64'(e_ifd));
            chk("dm_done", 64'(dm_done), 64'(e_dmd));
            chk("if_rdata", 64'(if_rdata), 64'(m_if_rd));
            chk("dm_rdata", 64'(dm_rdata), 64'(m_dm_rd));
            chk("stall_if", 64'(stall_if), 64'(if_req && !e_ifd));
            chk("stall_dm", 64'(stall_dm), 64'(dm_req && !e_dmd));
            chk("done_excl", 64'(if_done && dm_done), 64'(0));

            m_idle = !m_act;
            if (m_act && cyc == m_done) begin
                m_act = 0;
            end else if (e_req && mem_ready) begin
                m_rdy = 1;
                if (m_we) m_done = cyc + 1;
            end else if (m_act && m_rdy && m_done < 0 && mem_rvalid) begin
                if (m_dm) m_dm_rd = mem_rdata;
                else      m_if_rd = mem_rdata;
                m_done = cyc + 1;
            end
            if (m_idle && (if_req || dm_req)) begin
                if (dm_req && if_req && m_run < MAXS) begin
                    m_dm = 1;
                    m_run++;
                end else if (dm_req && !if_req) begin
                    m_dm  = 1;
                    m_run = 0;
                end else begin
                    m_dm  = 0;
                    m_run = 0;
                end
                m_act   = 1;
                m_rdy   = 0;
                m_g     = cyc;
                m_done  = -1;
                m_we    = m_dm && dm_we;
                m_addr  = m_dm ? dm_addr : if_addr;
                m_wdata = dm_wdata;
            end
        end
    end

    // ---------------- directed scenarios ----------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_quiet(input int budget, input string name);
        int n;
        n = 0;
        tick();
        while ((dm_busy || if_busy || dm_q.size() != 0 || if_q.size() != 0) && n < budget) begin
            tick();
            n++;
        end
        chk({name, "_timeout"}, 64'(n >= budget), 64'(0));
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_mem_req"}, 64'(mem_req), 64'(0));
        chk({tag, "_mem_we"}, 64'(mem_we), 64'(0));
        chk({tag, "_mem_addr"}, 64'(mem_addr), 64'(0));
        chk({tag, "_mem_wdata"}, 64'(mem_wdata), 64'(0));
        chk({tag, "_if_done"}, 64'(if_done), 64'(0));
        chk({tag, "_dm_done"}, 64'(dm_done), 64'(0));
        chk({tag, "_if_rdata"}, 64'(if_rdata), 64'(0));
        chk({tag, "_dm_rdata"}, 64'(dm_rdata), 64'(0));
    endtask

    int    snap, a0, n;
    string exp_ord;

    initial begin
        arst_n     = 1'b0;
        if_req     = 1'b0;
        if_addr    = '0;
        dm_req     = 1'b0;
        dm_we      = 1'b0;
        dm_addr    = '0;
        dm_wdata   = '0;
        mem_ready  = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
        mem_img[32'h0]   = 32'h00000013;
        mem_img[32'h4]   = 32'h00100093;
        mem_img[32'h8]   = 32'hCAFEF00D;
        mem_img[32'h10]  = 32'h11223344;
        mem_img[32'h100] = 32'hDEADBEEF;

        repeat (3) tick();
        chk_zero("reset");
        chk("reset_stall_if", 64'(stall_if), 64'(0));
        arst_n = 1'b1;
        repeat (2) tick();

        // single load
        dm_q.push_back('{we: 1'b0, addr: 32'h100, wdata: 32'h0});
        wait_quiet(50, "load");
        chk("load_latency", 64'(dm_lat), 64'(3));
        chk("load_rdata", 64'(dm_rd_last), 64'(32'hDEADBEEF));
        chk("load_no_if_done", 64'(if_done_seen), 64'(0));

        // store with three cycles of backpressure
        ready_delay = 3;
        snap = mreq_hi_cnt;
        dm_q.push_back('{we: 1'b1, addr: 32'h40, wdata: 32'h12345678});
        wait_quiet(50, "store");
        chk("store_req_cycles", 64'(mreq_hi_cnt - snap), 64'(4));
        chk("store_latency", 64'(dm_lat), 64'(5));
        chk("store_mem", 64'(mem_rd(32'h40)), 64'(32'h12345678));
        ready_delay = 0;

        // simultaneous fetch and load
        order_q.delete();
        if_q.push_back('{we: 1'b0, addr: 32'h0, wdata: 32'h0});
        dm_q.push_back('{we: 1'b0, addr: 32'h8, wdata: 32'h0});
        wait_quiet(50, "simul");
        chk("simul_count", 64'(order_q.size()), 64'(2));
        chk("simul_first_dm", 64'(order_q[0]), 64'(8'h44));
        chk("simul_if_latency", 64'(if_lat), 64'(7));
        chk("simul_if_rdata", 64'(if_rd_last), 64'(32'h00000013));

        // starvation guard: held fetch behind a continuous stream of stores
        order_q.delete();
        if_q.push_back('{we: 1'b0, addr: 32'h4, wdata: 32'h0});
        for (int i = 0; i < 6; i++) begin
            dm_q.push_back('{we: 1'b1, addr: 32'h200 + 32'(4 * i), wdata: 32'hA000_0000 + 32'(i)});
        end
        wait_quiet(200, "streak");
        exp_ord = "DDDDIDD";
        chk("streak_count", 64'(order_q.size()), 64'(7));
        for (int i = 0; i < 7; i++) begin
            chk($sformatf("streak_order_%0d", i), 64'(order_q[i]), 64'(exp_ord[i]));
        end
        chk("streak_if_rdata", 64'(if_rd_last), 64'(32'h00100093));

        // stray rvalid while idle
        tick();
        snap = dm_done_seen + if_done_seen;
        stray_idle_cycle = cyc + 1;
        repeat (3) tick();
        chk("stray_idle_dm_rdata", 64'(dm_rdata), 64'(32'hCAFEF00D));
        chk("stray_idle_if_rdata", 64'(if_rdata), 64'(32'h00100093));
        chk("stray_idle_no_done", 64'(dm_done_seen + if_done_seen), 64'(snap));

        // stray rvalid during issue backpressure
        ready_delay    = 2;
        stray_in_issue = 1;
        dm_q.push_back('{we: 1'b0, addr: 32'h10, wdata: 32'h0});
        wait_quiet(50, "stray_issue");
        chk("stray_issue_latency", 64'(dm_lat), 64'(5));
        chk("stray_issue_rdata", 64'(dm_rd_last), 64'(32'h11223344));
        stray_in_issue = 0;
        ready_delay    = 0;

        // reset while waiting for read data
        rv_delay = 4;
        a0 = acc_cnt;
        dm_q.push_back('{we: 1'b0, addr: 32'h100, wdata: 32'h0});
        n = 0;
        tick();
        while (acc_cnt == a0 && n < 20) begin
            tick();
            n++;
        end
        chk("rst_mid_accept_timeout", 64'(n >= 20), 64'(0));
        arst_n = 1'b0;
        #1;
        chk_zero("rst_mid");
        tick();
        arst_n = 1'b1;
        snap = dm_done_seen;
        repeat (5) tick();
        chk("rst_stale_no_done", 64'(dm_done_seen), 64'(snap));
        chk("rst_stale_dm_rdata", 64'(dm_rdata), 64'(0));
        rv_delay = 1;
        if_q.push_back('{we: 1'b0, addr: 32'h0, wdata: 32'h0});
        wait_quiet(50, "rst_fetch");
        chk("rst_fetch_latency", 64'(if_lat), 64'(3));
        chk("rst_fetch_rdata", 64'(if_rd_last), 64'(32'h00000013));

        repeat (3) tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global time bound
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

endmodule
